// File: rtl/mecanismo_puertas.sv
// Door mechanism model and driver for the elevator car.
// It turns the controller's open/close command into door motion. It reports
// the door state, the open-dwell timeout and the opening position. An
// obstruction while closing sends the doors back open.
//
// state    | meaning
// ---------+-------------------------------------------------
// CERRADA  | doors fully closed, waiting for an open command
// ABIERTA  | doors fully open, dwell timer running
// CERRANDO | doors moving towards closed, position counts down
// ABRIENDO | doors moving towards open, position counts up
module mecanismo_puertas #(
    parameter int T_RECORRIDO = 4,
    parameter int T_ESPERA    = 6,
    parameter int ANCHO_CNT   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           orden,
    input  logic                 trabajando,
    input  logic                 obstruccion,
    output logic [1:0]           puertas,
    output logic                 timeout,
    output logic [ANCHO_CNT-1:0] posicion,
    output logic                 en_movimiento,
    output logic [3:0]           reaperturas
);

    // The state code is the puertas output itself.
    typedef enum logic [1:0] {
        CERRADA  = 2'b00,
        ABIERTA  = 2'b01,
        CERRANDO = 2'b10,
        ABRIENDO = 2'b11
    } estado_t;

    localparam logic [ANCHO_CNT-1:0] RECORRIDO_C = ANCHO_CNT'(T_RECORRIDO);
    localparam logic [ANCHO_CNT-1:0] ESPERA_C    = ANCHO_CNT'(T_ESPERA);
    localparam logic [ANCHO_CNT-1:0] CERO_C      = '0;
    localparam logic [ANCHO_CNT-1:0] UNO_C       = ANCHO_CNT'(1);

    estado_t              estado_q, estado_d;
    logic [ANCHO_CNT-1:0] posicion_q, posicion_d;
    logic [ANCHO_CNT-1:0] dwell_q, dwell_d;
    logic                 timeout_q, timeout_d;
    logic [3:0]           reaperturas_q, reaperturas_d;

    logic                 cmd_abrir;
    logic                 cmd_cerrar;

    assign cmd_abrir  = trabajando && (orden == 2'b01);
    assign cmd_cerrar = trabajando && (orden == 2'b10);

    // State and counter registers; reset abandons any travel in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q      <= CERRADA;
            posicion_q    <= '0;
            dwell_q       <= '0;
            timeout_q     <= 1'b0;
            reaperturas_q <= '0;
        end else begin
            estado_q      <= estado_d;
            posicion_q    <= posicion_d;
            dwell_q       <= dwell_d;
            timeout_q     <= timeout_d;
            reaperturas_q <= reaperturas_d;
        end
    end

    // Next-state, position, dwell and reversal-count logic.
    always_comb begin
        estado_d      = estado_q;
        posicion_d    = posicion_q;
        dwell_d       = '0;
        timeout_d     = 1'b0;
        reaperturas_d = reaperturas_q;

        case (estado_q)
            CERRADA: begin
                if (cmd_abrir) begin
                    estado_d = ABRIENDO;
                end
            end

            ABRIENDO: begin
                // Clamp at full travel. A reversal taken at the fully open
                // position must not step past it.
                if (posicion_q >= RECORRIDO_C) begin
                    posicion_d = RECORRIDO_C;
                end else begin
                    posicion_d = posicion_q + UNO_C;
                end
                if (posicion_d == RECORRIDO_C) begin
                    estado_d = ABIERTA;
                end
            end

            ABIERTA: begin
                if (cmd_cerrar && !obstruccion) begin
                    estado_d = CERRANDO;
                end else if (cmd_abrir) begin
                    dwell_d = '0;
                end else begin
                    // A close command refused because of an obstruction
                    // lets the dwell run on as if no command came in.
                    if (dwell_q < ESPERA_C) begin
                        dwell_d = dwell_q + UNO_C;
                    end else begin
                        dwell_d = ESPERA_C;
                    end
                    timeout_d = (dwell_d >= ESPERA_C);
                end
            end

            CERRANDO: begin
                if (obstruccion || cmd_abrir) begin
                    estado_d = ABRIENDO;
                    if (obstruccion && (reaperturas_q != 4'hF)) begin
                        reaperturas_d = reaperturas_q + 4'd1;
                    end
                end else if (posicion_q <= UNO_C) begin
                    posicion_d = CERO_C;
                    estado_d   = CERRADA;
                end else begin
                    posicion_d = posicion_q - UNO_C;
                end
            end

            default: begin
                estado_d   = CERRADA;
                posicion_d = CERO_C;
            end
        endcase
    end

    assign puertas       = estado_q;
    assign en_movimiento = estado_q[1];
    assign posicion      = posicion_q;
    assign timeout       = timeout_q;
    assign reaperturas   = reaperturas_q;

endmodule

// File: tb/tb_mecanismo_puertas.sv
// Directed-vector bench for the elevator door mechanism.
module tb_mecanismo_puertas;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   orden;
    logic         trabajando;
    logic         obstruccion;
    logic [1:0]   puertas;
    logic         timeout;
    logic [W-1:0] posicion;
    logic         en_movimiento;
    logic [3:0]   reaperturas;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         rst;
        logic [1:0]   ord;
        logic         trab;
        logic         obs;
        logic [1:0]   e_puertas;
        logic [W-1:0] e_pos;
        logic         e_to;
        logic [3:0]   e_reap;
    } vec_t;

    vec_t vecs[$];

    mecanismo_puertas #(.T_RECORRIDO(4), .T_ESPERA(6), .ANCHO_CNT(W)) dut (
        .clk(clk), .reset(reset), .orden(orden), .trabajando(trabajando),
        .obstruccion(obstruccion), .puertas(puertas), .timeout(timeout),
        .posicion(posicion), .en_movimiento(en_movimiento),
        .reaperturas(reaperturas)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] ep, input int epos,
                           input logic eto, input int erp);
        chk({tag, " puertas"}, int'(puertas), int'(ep));
        chk({tag, " posicion"}, int'(posicion), epos);
        chk({tag, " timeout"}, int'(timeout), int'(eto));
        chk({tag, " en_movimiento"}, int'(en_movimiento), int'(ep[1]));
        chk({tag, " reaperturas"}, int'(reaperturas), erp);
    endtask

    task automatic add(input logic r, input logic [1:0] o, input logic t, input logic ob,
                       input logic [1:0] ep, input int epos, input logic eto, input int erp);
        vec_t v;
        v.rst = r; v.ord = o; v.trab = t; v.obs = ob;
        v.e_puertas = ep; v.e_pos = W'(epos); v.e_to = eto; v.e_reap = 4'(erp);
        vecs.push_back(v);
    endtask

    // One clock: drive inputs, let the edge happen, sample 1 time unit later.
    task automatic step(input logic [1:0] o, input logic t, input logic ob);
        orden = o; trabajando = t; obstruccion = ob;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; orden = 2'b00; trabajando = 1'b0; obstruccion = 1'b0;

        // rst ord trab obs | puertas pos to reap
        add(1, 2'b00, 0, 0, 2'b00, 0, 0, 0);  // reset state
        add(0, 2'b01, 0, 0, 2'b00, 0, 0, 0);  // trabajando=0 ignores open
        add(0, 2'b11, 1, 0, 2'b00, 0, 0, 0);  // orden=11 is no command
        add(0, 2'b00, 1, 1, 2'b00, 0, 0, 0);  // obstruction ignored when closed
        add(0, 2'b01, 1, 0, 2'b11, 0, 0, 0);  // edge 1: start opening
        add(0, 2'b10, 1, 0, 2'b11, 1, 0, 0);  // close ignored while opening
        add(0, 2'b00, 1, 1, 2'b11, 2, 0, 0);  // obstruction ignored while opening
        add(0, 2'b00, 1, 0, 2'b11, 3, 0, 0);
        add(0, 2'b00, 1, 0, 2'b01, 4, 0, 0);  // edge 5: fully open
        for (int i = 1; i <= 5; i++) add(0, 2'b00, 1, 0, 2'b01, 4, 0, 0);  // dwell 1..5
        add(0, 2'b01, 1, 0, 2'b01, 4, 0, 0);  // restart at dwell 5
        for (int i = 1; i <= 5; i++) add(0, 2'b00, 1, 0, 2'b01, 4, 0, 0);
        add(0, 2'b00, 1, 0, 2'b01, 4, 1, 0);  // 6 edges after restart
        add(0, 2'b00, 1, 0, 2'b01, 4, 1, 0);  // timeout holds
        add(0, 2'b10, 1, 1, 2'b01, 4, 1, 0);  // close refused by obstruction
        add(0, 2'b10, 0, 0, 2'b01, 4, 1, 0);  // close ignored, trabajando=0
        add(0, 2'b10, 1, 0, 2'b10, 4, 0, 0);  // edge N: closing, timeout cleared
        add(0, 2'b00, 1, 0, 2'b10, 3, 0, 0);
        add(0, 2'b00, 1, 0, 2'b10, 2, 0, 0);
        add(0, 2'b00, 1, 1, 2'b11, 2, 0, 1);  // obstruction reversal at pos 2
        add(0, 2'b00, 1, 0, 2'b11, 3, 0, 1);
        add(0, 2'b00, 1, 0, 2'b01, 4, 0, 1);
        add(0, 2'b10, 1, 0, 2'b10, 4, 0, 1);
        add(0, 2'b00, 1, 0, 2'b10, 3, 0, 1);
        add(0, 2'b01, 1, 0, 2'b11, 3, 0, 1);  // command reversal, not counted
        add(0, 2'b00, 1, 0, 2'b01, 4, 0, 1);
        add(0, 2'b10, 1, 0, 2'b10, 4, 0, 1);
        add(0, 2'b00, 1, 0, 2'b10, 3, 0, 1);
        add(0, 2'b00, 1, 0, 2'b10, 2, 0, 1);
        add(0, 2'b00, 1, 0, 2'b10, 1, 0, 1);
        add(0, 2'b01, 0, 0, 2'b00, 0, 0, 1);  // trabajando=0: closing completes
        add(0, 2'b00, 1, 0, 2'b00, 0, 0, 1);
        add(0, 2'b01, 1, 0, 2'b11, 0, 0, 1);
        add(0, 2'b00, 1, 0, 2'b11, 1, 0, 1);
        add(0, 2'b00, 1, 0, 2'b11, 2, 0, 1);
        add(0, 2'b00, 1, 0, 2'b11, 3, 0, 1);
        add(0, 2'b00, 1, 0, 2'b01, 4, 0, 1);
        add(0, 2'b10, 1, 0, 2'b10, 4, 0, 1);
        add(0, 2'b00, 1, 1, 2'b11, 4, 0, 2);  // reversal at full open position
        add(0, 2'b00, 1, 0, 2'b01, 4, 0, 2);  // no overshoot past 4
        add(0, 2'b10, 1, 0, 2'b10, 4, 0, 2);
        add(0, 2'b00, 1, 0, 2'b10, 3, 0, 2);
        add(0, 2'b00, 1, 0, 2'b10, 2, 0, 2);
        add(0, 2'b00, 1, 0, 2'b10, 1, 0, 2);
        add(0, 2'b00, 1, 1, 2'b11, 1, 0, 3);  // reversal beats completion at 1
        add(0, 2'b00, 1, 0, 2'b11, 2, 0, 3);
        add(0, 2'b00, 1, 0, 2'b11, 3, 0, 3);
        add(0, 2'b00, 1, 0, 2'b01, 4, 0, 3);

        #2;
        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            step(vecs[i].ord, vecs[i].trab, vecs[i].obs);
            chk_all($sformatf("vec%0d", i), vecs[i].e_puertas, int'(vecs[i].e_pos),
                    vecs[i].e_to, int'(vecs[i].e_reap));
        end

        // Saturation of the reversal counter over 16 more reversals.
        for (int i = 1; i <= 16; i++) begin
            step(2'b10, 1, 0);
            chk($sformatf("sat%0d closing", i), int'(puertas), 2);
            step(2'b00, 1, 1);
            chk($sformatf("sat%0d reaperturas", i), int'(reaperturas),
                (3 + i > 15) ? 15 : 3 + i);
            step(2'b00, 1, 0);
            chk($sformatf("sat%0d reopened", i), int'(puertas), 1);
        end
        chk("sat final", int'(reaperturas), 15);

        // Asynchronous reset between edges while closing at position 3.
        step(2'b10, 1, 0);
        step(2'b00, 1, 0);
        chk_all("pre_reset", 2'b10, 3, 0, 15);
        #2;
        reset = 1'b1;
        #1;
        chk_all("async_reset", 2'b00, 0, 0, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(2'b00, 1, 0);
            chk_all($sformatf("post_reset%0d", i), 2'b00, 0, 0, 0);
        end
        step(2'b01, 1, 0);
        chk_all("post_reset_open", 2'b11, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mecanismo_puertas.md
Name: mecanismo_puertas

Overview:
- Door mechanism model and driver for the elevator car.
- Receives the open/close command and the working flag from the door controller.
- Produces the door-state code, open-dwell timeout and position that the door controller consumes, so it closes the control loop.
- Includes the physical obstruction safety reversal.

Parameters:
- T_RECORRIDO, 4: cycles of motion for full travel between closed and open.
- T_ESPERA, 6: cycles spent in the open state before timeout asserts.
- ANCHO_CNT, 8: width of the position and dwell counters; must hold max(T_RECORRIDO, T_ESPERA).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- orden  input  2  door command: 01 open, 10 close, 00 or 11 none.
- trabajando  input  1  controller working flag; orden is ignored when 0.
- obstruccion  input  1  physical obstruction between the doors.
- puertas  output  2  door state: 00 closed, 01 fully open, 10 closing, 11 opening.
- timeout  output  1  open-dwell expired.
- posicion  output  ANCHO_CNT  door opening, 0 = closed, T_RECORRIDO = fully open.
- en_movimiento  output  1  high while opening or closing.
- reaperturas  output  4  count of obstruction reversals, saturating at 15.

Behaviour:
- Clocking: one clock. All registers update on the rising edge of clk. Every output is registered.
- Reset: asynchronous, active-high. While asserted: state CERRADA, puertas=00, posicion=0, dwell=0, timeout=0, en_movimiento=0, reaperturas=0. Applies mid-motion with no completion of travel.
- State encoding: the state register is puertas itself (CERRADA 00, ABIERTA 01, CERRANDO 10, ABRIENDO 11). en_movimiento = puertas[1].
- Valid command: cmd_abrir = trabajando & orden==01; cmd_cerrar = trabajando & orden==10. orden=11 is treated as 00.
- CERRADA:
  - cmd_abrir -> ABRIENDO; posicion unchanged on the entry edge.
  - Otherwise stay. obstruccion has no effect.
- ABRIENDO:
  - Each edge posicion+1.
  - When the new value equals T_RECORRIDO -> ABIERTA on that same edge, with dwell cleared.
  - cmd_cerrar and obstruccion are ignored; opening always completes.
  - From closed, the state lasts T_RECORRIDO edges.
- ABIERTA:
  - Each edge dwell+1, saturating at T_ESPERA.
  - timeout is registered high on the edge where dwell reaches T_ESPERA, and holds while in ABIERTA.
  - cmd_abrir restarts dwell at 0 and clears timeout.
  - cmd_cerrar -> CERRANDO, with dwell=0 and timeout=0 on that edge. If obstruccion=1 on the same edge, the close command is refused and the state stays ABIERTA.
- CERRANDO:
  - Reversal priority: if obstruccion or cmd_abrir -> ABRIENDO on the next edge. posicion holds (no decrement) on that edge, and the reversal starts from the current position.
  - If the reversal cause includes obstruccion, reaperturas+1 (saturating at 15).
  - Otherwise posicion-1 each edge; when the new value equals 0 -> CERRADA on the same edge.
  - Reversal beats completion even at posicion=1.
- trabajando=0: commands are ignored, but motion in progress completes and dwell/timeout keep running in ABIERTA.
- posicion never leaves the range 0..T_RECORRIDO. No wrap-around.

Test Plan:
- Normal opening (T_RECORRIDO=4, T_ESPERA=6): reset, then orden=01 with trabajando=1 sampled at edge 1.
  - puertas=11 after edge 1.
  - posicion 1,2,3,4 after edges 2-5.
  - puertas=01 and en_movimiento=0 after edge 5.
  - timeout=1 after edge 11.
- Closing after timeout: in ABIERTA with timeout=1, orden=10 at edge N.
  - puertas=10 and timeout=0 after edge N.
  - posicion 3,2,1,0 over edges N+1..N+4.
  - puertas=00 after edge N+4.
- Obstruction reversal: obstruccion=1 during CERRANDO at posicion=2.
  - Next edge: puertas=11, posicion=2, reaperturas=1.
  - puertas=01 two edges later at posicion=4.
  - Repeat 16 times: reaperturas stays at 15.
- Ignored commands:
  - orden=10 during ABRIENDO: opening completes unchanged.
  - orden=11 or trabajando=0 with orden=01 in CERRADA: puertas stays 00, posicion stays 0.
- Dwell restart: in ABIERTA with dwell=5, orden=01 for one edge.
  - timeout=0.
  - timeout asserts 6 edges after the restart edge.
- Reset mid-operation: assert reset asynchronously, between clock edges, during CERRANDO at posicion=3.
  - All outputs zero immediately, before the next clock edge.
  - After release, the block stays in CERRADA until a valid open command.
